spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
- Shares one spi_master_mode0 byte engine among NREQ requesters.
- Grants one requester at a time (round-robin) and holds that requester's chip select low for a whole multi-byte transaction.
- Feeds bytes to the engine one at a time and returns received bytes, tagged with the owning requester.
- Sits between the client blocks and the byte engine. It owns start/tx_data into the engine and the per-device cs_n lines toward the pads; the engine's own cs_n is left unused.

Parameters:
- NREQ, 4, number of requesters/devices.
- LEN_W, 4, width of the per-requester length field; byte count = req_len+1 (1..2^LEN_W).
- CS_SETUP, 2, cycles cs_n is low before the first byte start (>=1).
- CS_HOLD, 2, cycles cs_n stays low after the last byte's spi_done (>=1).
- CS_IDLE, 2, minimum cycles all cs_n are high between transactions (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  transaction request per requester; held until its xfer_done
- req_len  in  NREQ*LEN_W  byte count minus 1, slice i for requester i; sampled at grant
- tx_data  in  NREQ*8  next byte to send, slice i for requester i
- tx_valid  in  NREQ  tx_data slice valid
- tx_ready  out  NREQ  byte accepted when tx_valid[i]&tx_ready[i]
- gnt  out  NREQ  one-hot current owner, high from grant through RELEASE
- xfer_done  out  NREQ  1-cycle pulse to the owner at end of transaction
- rx_data  out  8  byte received from the engine
- rx_valid  out  1  1-cycle pulse, rx_data valid for the current owner
- rx_last  out  1  qualifies rx_valid: final byte of the transaction
- cs_n  out  NREQ  per-device chip select, active-low
- spi_start  out  1  1-cycle start pulse to the byte engine
- spi_tx_data  out  8  byte to the engine, stable from spi_start to spi_done
- spi_busy  in  1  engine busy
- spi_done  in  1  engine 1-cycle done
- spi_rx_data  in  8  engine received byte, valid with spi_done

Behaviour:
- Reset values: all outputs 0 except cs_n = all ones. FSM=IDLE, RR pointer = NREQ-1, so requester 0 wins first.
- States:
  - IDLE: if any req, select the first set req[i] searching from pointer+1 mod NREQ. Register owner, pointer=i, byte counter=req_len[i]. gnt[i]=1 and cs_n[i]=0 on the next cycle; go to SETUP.
  - SETUP: count CS_SETUP cycles, then go to LOAD.
  - LOAD: tx_ready[owner]=1 (other tx_ready 0). On tx_valid[owner], capture the byte into spi_tx_data, drop tx_ready the next cycle, go to START. LOAD may stall indefinitely.
  - START: if !spi_busy, assert spi_start for exactly one cycle, go to WAIT; else stay in START.
  - WAIT: on spi_done, rx_data<=spi_rx_data and rx_valid=1 for 1 cycle. rx_last=1 if counter==0. If counter!=0, decrement and go to LOAD; else go to HOLD.
  - HOLD: count CS_HOLD cycles, then go to RELEASE.
  - RELEASE: cs_n all high, pulse xfer_done[owner] once, gnt cleared. Count CS_IDLE cycles, then go to IDLE.
- Latency: req in IDLE -> cs_n low 1 cycle later -> tx_ready CS_SETUP cycles after that.
- Exactly one gnt bit and at most one cs_n low at any time. No cs_n is low outside SETUP..HOLD.
- req deasserted mid-transaction: ignored; the transaction completes its sampled length. req_len changes after grant: ignored.
- Simultaneous reqs: only one is granted; the others wait. A requester re-asserting immediately is served after all others pending (round-robin fairness).
- spi_done outside WAIT: ignored. spi_tx_data is held constant outside LOAD.
- rst mid-transaction: next cycle IDLE, cs_n all high, spi_start/rx_valid/xfer_done 0, no pulse generated. The byte engine is reset by its own reset.

Test Plan:
- Single requester: req[0], len=0, tx 8'hA5, slave MISO 8'h3C -> cs_n[0] low 1 cycle after req; exactly one spi_start; rx_data=8'h3C with rx_valid&rx_last; xfer_done[0] one pulse; cs_n[0] high after CS_HOLD.
- Multi-byte: req[2], len=2, tx 8'h11,8'h22,8'h33, MISO 8'hAA,8'h55,8'hFF -> three rx_valid pulses in that order; rx_last only on 8'hFF; cs_n[2] continuously low across all bytes.
- Arbitration: req=4'b1011 asserted together, each len=0 -> grant order 0,1,3; at least CS_IDLE all-high cycles between transactions; never two cs_n low.
- Fairness: req[0] re-asserted right after its xfer_done while req[1] pending -> requester 1 served before 0's second transaction.
- Stall: tx_valid[1] held low 20 cycles in LOAD -> no spi_start, cs_n[1] stays low; byte sent once tx_valid rises.
- Reset mid-op: rst pulsed during WAIT of byte 2 of a len=3 transfer -> next cycle cs_n=4'b1111, gnt=0, no xfer_done; a subsequent req[3] transfer completes normally.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Purpose : round-robin arbiter sharing one SPI byte engine among NREQ requesters;
//           the owner's cs_n is held low for its whole multi-byte transaction.
// Latency : req -> gnt/cs_n low next cycle -> tx_ready CS_SETUP cycles later; one byte per engine spi_done.
// Backpressure: tx_ready only to the owner in LOAD (stalls indefinitely on tx_valid); START waits for !spi_busy.
// Ports   : req/req_len/tx_data/tx_valid/tx_ready  - requester side (slice i = requester i)
//           gnt/xfer_done/rx_data/rx_valid/rx_last - grant, completion and received-byte return
//           cs_n                                   - per-device chip selects toward the pads
//           spi_start/spi_tx_data/spi_busy/spi_done/spi_rx_data - byte engine handshake
module spi_xfer_arbiter #(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ*8-1:0]       tx_data,
  input  logic [NREQ-1:0]         tx_valid,
  output logic [NREQ-1:0]         tx_ready,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         xfer_done,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  output logic                    rx_last,
  output logic [NREQ-1:0]         cs_n,
  output logic                    spi_start,
  output logic [7:0]              spi_tx_data,
  input  logic                    spi_busy,
  input  logic                    spi_done,
  input  logic [7:0]              spi_rx_data
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_START, S_WAIT, S_HOLD, S_RELEASE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    cs_n_q;
  logic [NREQ-1:0]    tx_ready_q;
  logic [NREQ-1:0]    xfer_done_q;
  logic [7:0]         rx_data_q;
  logic               rx_valid_q;
  logic               rx_last_q;
  logic               spi_start_q;
  logic [7:0]         spi_tx_data_q;

  logic               any_req_d;
  logic [IDX_W-1:0]   sel_d;
  logic [IDX_W-1:0]   cand;
  logic [NREQ-1:0]    sel_oh;
  logic [NREQ-1:0]    owner_oh;

  // Search starts just after the last winner, so a requester that re-asserts
  // immediately goes behind everyone already pending.
  always_comb begin
    any_req_d = 1'b0;
    sel_d     = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NREQ);
      if (!any_req_d && req[cand]) begin
        any_req_d = 1'b1;
        sel_d     = cand;
      end
    end
  end

  assign sel_oh   = NREQ'(1) << sel_d;
  assign owner_oh = NREQ'(1) << owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= IDX_W'(NREQ - 1);
      owner_q       <= '0;
      cnt_q         <= '0;
      tmr_q         <= '0;
      gnt_q         <= '0;
      cs_n_q        <= '1;
      tx_ready_q    <= '0;
      xfer_done_q   <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_last_q     <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_tx_data_q <= '0;
    end else begin
      // single-cycle pulses
      spi_start_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      xfer_done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            owner_q <= sel_d;
            ptr_q   <= sel_d;
            cnt_q   <= req_len[int'(sel_d)*LEN_W +: LEN_W];
            gnt_q   <= sel_oh;
            cs_n_q  <= ~sel_oh;
            tmr_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
            tmr_q      <= '0;
            tx_ready_q <= owner_oh;
            state_q    <= S_LOAD;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_LOAD: begin
          if (tx_valid[owner_q]) begin
            spi_tx_data_q <= tx_data[int'(owner_q)*8 +: 8];
            tx_ready_q    <= '0;
            state_q       <= S_START;
          end
        end
        S_START: begin
          if (!spi_busy) begin
            spi_start_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (spi_done) begin
            rx_data_q  <= spi_rx_data;
            rx_valid_q <= 1'b1;
            rx_last_q  <= (cnt_q == '0);
            if (cnt_q != '0) begin
              cnt_q      <= cnt_q - LEN_W'(1);
              tx_ready_q <= owner_oh;
              state_q    <= S_LOAD;
            end else begin
              tmr_q   <= '0;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
            tmr_q       <= '0;
            cs_n_q      <= '1;
            xfer_done_q <= owner_oh;
            state_q     <= S_RELEASE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_RELEASE: begin
          // gnt stays with the owner until the idle gap has elapsed
          if (tmr_q == TMR_W'(CS_IDLE - 1)) begin
            tmr_q   <= '0;
            gnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready    = tx_ready_q;
  assign gnt         = gnt_q;
  assign xfer_done   = xfer_done_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_last     = rx_last_q;
  assign cs_n        = cs_n_q;
  assign spi_start   = spi_start_q;
  assign spi_tx_data = spi_tx_data_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Purpose : directed bench for spi_xfer_arbiter with a byte-engine model and per-requester byte feeders.
// Latency : engine model raises spi_done 4 cycles after seeing spi_start.
// Backpressure: feeders present tx_valid whenever bytes are queued, except while stalled.
module tb_spi_xfer_arbiter;
  localparam int NREQ  = 4;
  localparam int LEN_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*8-1:0]     tx_data;
  logic [NREQ-1:0]       tx_valid;
  logic [NREQ-1:0]       tx_ready;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       xfer_done;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_last;
  logic [NREQ-1:0]       cs_n;
  logic                  spi_start;
  logic [7:0]            spi_tx_data;
  logic                  spi_busy;
  logic                  spi_done;
  logic [7:0]            spi_rx_data;

  int n_tests = 0;
  int n_fail  = 0;

  spi_xfer_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .gnt(gnt), .xfer_done(xfer_done),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .cs_n(cs_n),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data)
  );

  always #5 clk = ~clk;

  // ---------------- byte engine model ----------------
  logic [7:0] miso_tab[64];
  int         miso_wr = 0, miso_rd = 0;
  logic [7:0] sent_tab[64];
  int         n_sent = 0;
  int         eng_cnt = 0;

  initial begin
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (rst) begin
        spi_busy = 1'b0;
      end else if (spi_busy) begin
        if (eng_cnt == 0) begin
          spi_done = 1'b1;
          spi_busy = 1'b0;
          if (miso_rd < miso_wr) begin
            spi_rx_data = miso_tab[miso_rd];
            miso_rd++;
          end else begin
            spi_rx_data = 8'h00;
          end
        end else begin
          eng_cnt--;
        end
      end else if (spi_start) begin
        spi_busy = 1'b1;
        eng_cnt  = 3;
        if (n_sent < 64) sent_tab[n_sent] = spi_tx_data;
        n_sent++;
      end
    end
  end

  // ---------------- requester byte feeders ----------------
  logic [7:0] tx_tab[NREQ][16];
  int         tx_n[NREQ];
  int         tx_idx[NREQ];
  logic       acc_pend[NREQ];
  logic       stall[NREQ];

  initial begin
    tx_valid = '0; tx_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      tx_n[i] = 0; tx_idx[i] = 0; acc_pend[i] = 1'b0; stall[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (acc_pend[i]) tx_idx[i]++;
        if (tx_idx[i] < tx_n[i] && !stall[i]) begin
          tx_valid[i] = 1'b1;
          tx_data[i*8 +: 8] = tx_tab[i][tx_idx[i]];
        end else begin
          tx_valid[i] = 1'b0;
        end
        acc_pend[i] = tx_valid[i] && tx_ready[i] && !rst;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0]      rx_dat_log[64];
  logic            rx_last_log[64];
  int              rx_own_log[64];
  int              n_rx = 0;
  int              gnt_log[16];
  int              n_gnt = 0;
  int              done_cnt[NREQ];
  int              mon_starts = 0;
  int              multi_low = 0;
  int              gap_run = 0, gap_min = 1000;
  bit              seen_low = 1'b0, prev_high = 1'b1;
  int              cs_rise_cnt = 0, cs_rise_cyc = 0, last_rx_cyc = 0, ncyc = 0;
  int              lows;
  logic [NREQ-1:0] prev_gnt = '0;

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (spi_start) mon_starts++;
      if (rx_valid && n_rx < 64) begin
        rx_dat_log[n_rx]  = rx_data;
        rx_last_log[n_rx] = rx_last;
        rx_own_log[n_rx]  = oh2i(gnt);
        n_rx++;
        last_rx_cyc = ncyc;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (xfer_done[i]) begin
          done_cnt[i]++;
          req[i] = 1'b0;
        end
      end
      if (gnt != '0 && gnt != prev_gnt && n_gnt < 16) begin
        gnt_log[n_gnt] = oh2i(gnt);
        n_gnt++;
      end
      prev_gnt = gnt;
      lows = 0;
      for (int i = 0; i < NREQ; i++) if (!cs_n[i]) lows++;
      if (lows > 1) multi_low++;
      if (cs_n == '1) begin
        gap_run++;
        if (!prev_high) begin
          cs_rise_cnt++;
          cs_rise_cyc = ncyc;
        end
      end else begin
        if (prev_high && seen_low && gap_run < gap_min) gap_min = gap_run;
        gap_run  = 0;
        seen_low = 1'b1;
      end
      prev_high = (cs_n == '1);
    end
  end

  task automatic clear_logs();
    n_rx = 0; n_gnt = 0; mon_starts = 0; multi_low = 0;
    gap_run = 0; gap_min = 1000; seen_low = 1'b0; cs_rise_cnt = 0;
    n_sent = 0; miso_wr = 0; miso_rd = 0;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    for (int i = 0; i < NREQ; i++) begin
      tx_n[i] = 0; tx_idx[i] = 0; stall[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cs_n !== 4'hF) begin n_fail++; $display("FAIL reset_cs_n: got %h want f", cs_n); end
    n_tests++;
    if ({gnt, tx_ready, xfer_done} !== 12'h000) begin
      n_fail++; $display("FAIL reset_gnt_rdy_done: got %h want 000", {gnt, tx_ready, xfer_done});
    end
    n_tests++;
    if ({spi_start, rx_valid, rx_last, rx_data, spi_tx_data} !== 19'h0) begin
      n_fail++; $display("FAIL reset_pulses_data: got %h want 0", {spi_start, rx_valid, rx_last, rx_data, spi_tx_data});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({cs_n, gnt} !== 8'hF0) begin n_fail++; $display("FAIL reset_idle: got %h want f0", {cs_n, gnt}); end
  endtask

  task automatic test_single();
    clear_logs();
    req_len[3:0] = 4'd0;
    tx_tab[0][0] = 8'hA5; tx_idx[0] = 0; tx_n[0] = 1;
    miso_tab[0] = 8'h3C; miso_wr = 1;
    @(negedge clk);
    req[0] = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({cs_n, gnt} !== 8'hE1) begin n_fail++; $display("FAIL single_grant: got %h want e1", {cs_n, gnt}); end
    @(negedge clk);
    n_tests++;
    if (tx_ready !== 4'h0) begin n_fail++; $display("FAIL single_setup_rdy: got %h want 0", tx_ready); end
    @(negedge clk);
    n_tests++;
    if (tx_ready !== 4'h1) begin n_fail++; $display("FAIL single_load_rdy: got %h want 1", tx_ready); end
    for (int k = 0; k < 300 && done_cnt[0] < 1; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    n_tests++;
    if ({done_cnt[0], mon_starts, n_rx} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL single_counts: done/starts/rx got %0d/%0d/%0d want 1/1/1", done_cnt[0], mon_starts, n_rx);
    end
    n_tests++;
    if ({sent_tab[0], rx_dat_log[0], rx_last_log[0]} !== {8'hA5, 8'h3C, 1'b1}) begin
      n_fail++; $display("FAIL single_data: tx/rx/last got %h/%h/%b want a5/3c/1", sent_tab[0], rx_dat_log[0], rx_last_log[0]);
    end
    n_tests++;
    if (cs_rise_cyc - last_rx_cyc !== 2) begin
      n_fail++; $display("FAIL single_cs_hold: got %0d cycles want 2", cs_rise_cyc - last_rx_cyc);
    end
    n_tests++;
    if ({cs_n, gnt} !== 8'hF0) begin n_fail++; $display("FAIL single_idle_after: got %h want f0", {cs_n, gnt}); end
  endtask

  task automatic test_multi();
    clear_logs();
    req_len[11:8] = 4'd2;
    tx_tab[2][0] = 8'h11; tx_tab[2][1] = 8'h22; tx_tab[2][2] = 8'h33; tx_idx[2] = 0; tx_n[2] = 3;
    miso_tab[0] = 8'hAA; miso_tab[1] = 8'h55; miso_tab[2] = 8'hFF; miso_wr = 3;
    @(negedge clk);
    req[2] = 1'b1;
    repeat (2) @(negedge clk);
    req_len[11:8] = 4'd0;  // late change must not shorten the transaction
    for (int k = 0; k < 400 && done_cnt[2] < 1; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    n_tests++;
    if ({n_rx, mon_starts, done_cnt[2]} !== {32'd3, 32'd3, 32'd1}) begin
      n_fail++; $display("FAIL multi_counts: rx/starts/done got %0d/%0d/%0d want 3/3/1", n_rx, mon_starts, done_cnt[2]);
    end
    n_tests++;
    if ({rx_dat_log[0], rx_dat_log[1], rx_dat_log[2]} !== 24'hAA55FF) begin
      n_fail++; $display("FAIL multi_rx_data: got %h want aa55ff", {rx_dat_log[0], rx_dat_log[1], rx_dat_log[2]});
    end
    n_tests++;
    if ({rx_last_log[0], rx_last_log[1], rx_last_log[2]} !== 3'b001) begin
      n_fail++; $display("FAIL multi_rx_last: got %b want 001", {rx_last_log[0], rx_last_log[1], rx_last_log[2]});
    end
    n_tests++;
    if ({rx_own_log[0], rx_own_log[1], rx_own_log[2]} !== {32'd2, 32'd2, 32'd2}) begin
      n_fail++; $display("FAIL multi_owner: got %0d %0d %0d want 2 2 2", rx_own_log[0], rx_own_log[1], rx_own_log[2]);
    end
    n_tests++;
    if ({sent_tab[0], sent_tab[1], sent_tab[2]} !== 24'h112233) begin
      n_fail++; $display("FAIL multi_tx_data: got %h want 112233", {sent_tab[0], sent_tab[1], sent_tab[2]});
    end
    n_tests++;
    if (cs_rise_cnt !== 1) begin n_fail++; $display("FAIL multi_cs_continuous: rises got %0d want 1", cs_rise_cnt); end
  endtask

  task automatic test_arbitration();
    do_reset();
    clear_logs();
    req_len = '0;
    tx_tab[0][0] = 8'h01; tx_idx[0] = 0; tx_n[0] = 1;
    tx_tab[1][0] = 8'h02; tx_idx[1] = 0; tx_n[1] = 1;
    tx_tab[3][0] = 8'h08; tx_idx[3] = 0; tx_n[3] = 1;
    miso_tab[0] = 8'h91; miso_tab[1] = 8'h92; miso_tab[2] = 8'h98; miso_wr = 3;
    req = 4'b1011;
    for (int k = 0; k < 600 && (done_cnt[0] + done_cnt[1] + done_cnt[3]) < 3; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    n_tests++;
    if ({n_gnt, gnt_log[0], gnt_log[1], gnt_log[2]} !== {32'd3, 32'd0, 32'd1, 32'd3}) begin
      n_fail++; $display("FAIL arb_order: n=%0d got %0d %0d %0d want 0 1 3", n_gnt, gnt_log[0], gnt_log[1], gnt_log[2]);
    end
    n_tests++;
    if (multi_low !== 0) begin n_fail++; $display("FAIL arb_multi_cs_low: got %0d cycles want 0", multi_low); end
    n_tests++;
    if (gap_min < 2) begin n_fail++; $display("FAIL arb_idle_gap: got %0d want >=2", gap_min); end
    n_tests++;
    if ({rx_dat_log[0], rx_dat_log[1], rx_dat_log[2]} !== 24'h919298) begin
      n_fail++; $display("FAIL arb_rx_data: got %h want 919298", {rx_dat_log[0], rx_dat_log[1], rx_dat_log[2]});
    end
    n_tests++;
    if ({done_cnt[0], done_cnt[1], done_cnt[2], done_cnt[3]} !== {32'd1, 32'd1, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL arb_done: got %0d %0d %0d %0d want 1 1 0 1", done_cnt[0], done_cnt[1], done_cnt[2], done_cnt[3]);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    clear_logs();
    req_len = '0;
    tx_tab[0][0] = 8'hC1; tx_tab[0][1] = 8'hC2; tx_idx[0] = 0; tx_n[0] = 2;
    tx_tab[1][0] = 8'hD1; tx_idx[1] = 0; tx_n[1] = 1;
    miso_tab[0] = 8'hE1; miso_tab[1] = 8'hE2; miso_tab[2] = 8'hE3; miso_wr = 3;
    req[0] = 1'b1;
    for (int k = 0; k < 50 && !gnt[0]; k++) @(negedge clk);
    req[1] = 1'b1;
    for (int k = 0; k < 300 && done_cnt[0] < 1; k++) @(negedge clk);
    @(negedge clk);
    req[0] = 1'b1;
    for (int k = 0; k < 600 && (done_cnt[0] + done_cnt[1]) < 3; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    n_tests++;
    if ({n_gnt, gnt_log[0], gnt_log[1], gnt_log[2]} !== {32'd3, 32'd0, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL fair_order: n=%0d got %0d %0d %0d want 0 1 0", n_gnt, gnt_log[0], gnt_log[1], gnt_log[2]);
    end
    n_tests++;
    if ({sent_tab[0], sent_tab[1], sent_tab[2]} !== 24'hC1D1C2) begin
      n_fail++; $display("FAIL fair_tx_order: got %h want c1d1c2", {sent_tab[0], sent_tab[1], sent_tab[2]});
    end
    n_tests++;
    if ({done_cnt[0], done_cnt[1]} !== {32'd2, 32'd1}) begin
      n_fail++; $display("FAIL fair_done: got %0d %0d want 2 1", done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_stall();
    int cs_high_cnt;
    clear_logs();
    cs_high_cnt = 0;
    req_len[7:4] = 4'd0;
    stall[1] = 1'b1;
    tx_tab[1][0] = 8'h5A; tx_idx[1] = 0; tx_n[1] = 1;
    miso_tab[0] = 8'h6B; miso_wr = 1;
    req[1] = 1'b1;
    for (int k = 0; k < 50 && !tx_ready[1]; k++) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cs_n[1]) cs_high_cnt++;
    end
    n_tests++;
    if ({mon_starts, cs_high_cnt} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL stall_hold: starts/cs_high got %0d/%0d want 0/0", mon_starts, cs_high_cnt);
    end
    n_tests++;
    if (tx_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_rdy: got %b want 0010", tx_ready); end
    stall[1] = 1'b0;
    for (int k = 0; k < 300 && done_cnt[1] < 1; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    n_tests++;
    if ({mon_starts, done_cnt[1]} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL stall_resume: starts/done got %0d/%0d want 1/1", mon_starts, done_cnt[1]);
    end
    n_tests++;
    if ({sent_tab[0], rx_dat_log[0]} !== 16'h5A6B) begin
      n_fail++; $display("FAIL stall_data: got %h want 5a6b", {sent_tab[0], rx_dat_log[0]});
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    req_len[7:4] = 4'd3;
    tx_tab[1][0] = 8'h31; tx_tab[1][1] = 8'h32; tx_tab[1][2] = 8'h33; tx_tab[1][3] = 8'h34;
    tx_idx[1] = 0; tx_n[1] = 4;
    miso_tab[0] = 8'h41; miso_tab[1] = 8'h42; miso_tab[2] = 8'h43; miso_tab[3] = 8'h44; miso_wr = 4;
    req[1] = 1'b1;
    for (int k = 0; k < 300 && mon_starts < 2; k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; req = '0; tx_n[1] = 0; tx_idx[1] = 0;
    @(negedge clk);
    n_tests++;
    if ({cs_n, gnt, xfer_done} !== 12'hF00) begin
      n_fail++; $display("FAIL rstmid_outputs: cs_n/gnt/done got %h want f00", {cs_n, gnt, xfer_done});
    end
    n_tests++;
    if ({spi_start, rx_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_pulses: got %b want 00", {spi_start, rx_valid});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if ({done_cnt[1], n_rx} !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL rstmid_no_done: done/rx got %0d/%0d want 0/1", done_cnt[1], n_rx);
    end
    clear_logs();
    req_len[15:12] = 4'd1;
    tx_tab[3][0] = 8'h77; tx_tab[3][1] = 8'h88; tx_idx[3] = 0; tx_n[3] = 2;
    miso_tab[0] = 8'h12; miso_tab[1] = 8'h34; miso_wr = 2;
    req[3] = 1'b1;
    for (int k = 0; k < 400 && done_cnt[3] < 1; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    n_tests++;
    if ({done_cnt[3], n_rx} !== {32'd1, 32'd2}) begin
      n_fail++; $display("FAIL rstmid_after_counts: done/rx got %0d/%0d want 1/2", done_cnt[3], n_rx);
    end
    n_tests++;
    if ({rx_dat_log[0], rx_dat_log[1], rx_last_log[0], rx_last_log[1]} !== {16'h1234, 2'b01}) begin
      n_fail++; $display("FAIL rstmid_after_rx: got %h %h %b%b want 12 34 01", rx_dat_log[0], rx_dat_log[1], rx_last_log[0], rx_last_log[1]);
    end
    n_tests++;
    if ({sent_tab[0], sent_tab[1]} !== 16'h7788) begin
      n_fail++; $display("FAIL rstmid_after_tx: got %h want 7788", {sent_tab[0], sent_tab[1]});
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_len = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_arbitration();
    test_fairness();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
